// File: rtl/dual_port_bus_mem_pkg.sv
// Shared constants and address-decode helpers for the dual-port bus memory.
package dual_port_bus_mem_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BE_W          = 4;
    localparam int unsigned DEF_MEM_WORDS = 16384;

    // Word index of a byte address relative to the base; addr[1:0] drop out.
    function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr,
                                                     input logic [ADDR_W-1:0] base);
        return (addr - base) >> 2;
    endfunction

    // True when the byte address falls inside the mapped word array.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input int unsigned       words);
        return (addr >= base) && (word_index(addr, base) < words);
    endfunction

endpackage

// File: rtl/dual_port_bus_mem_if.sv
// Instruction and data request/grant/valid buses between core and memory.
interface dual_port_bus_mem_if;
    import dual_port_bus_mem_pkg::*;

    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_gnt;
    logic [DATA_W-1:0] instr_rdata;
    logic              instr_err;
    logic              instr_valid;

    logic              data_req;
    logic              data_wr;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [BE_W-1:0]   data_byteen;
    logic              data_gnt;
    logic [DATA_W-1:0] data_rdata;
    logic              data_valid;

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rdata, instr_err, instr_valid,
        output data_req, data_wr, data_addr, data_wdata, data_byteen,
        input  data_gnt, data_rdata, data_valid
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rdata, instr_err, instr_valid,
        input  data_req, data_wr, data_addr, data_wdata, data_byteen,
        output data_gnt, data_rdata, data_valid
    );

endinterface

// File: rtl/dual_port_bus_mem.sv
// Single-cycle-latency simulation memory with a read-only instruction port
// and a read/write data port sharing one word array (mem).
module dual_port_bus_mem
    import dual_port_bus_mem_pkg::*;
#(
    parameter int unsigned       MEM_WORDS = DEF_MEM_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset_n,
    dual_port_bus_mem_if.slave bus
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic             i_hit;
    logic             d_hit;
    logic [IDX_W-1:0] i_idx;
    logic [IDX_W-1:0] d_idx;

    // Always ready: a request is granted in the cycle it is raised, except in reset.
    assign bus.instr_gnt = bus.instr_req & reset_n;
    assign bus.data_gnt  = bus.data_req  & reset_n;

    // Address decode for both ports.
    always_comb begin
        i_hit = in_range(bus.instr_addr, BASE_ADDR, MEM_WORDS);
        d_hit = in_range(bus.data_addr,  BASE_ADDR, MEM_WORDS);
        i_idx = IDX_W'(word_index(bus.instr_addr, BASE_ADDR));
        d_idx = IDX_W'(word_index(bus.data_addr,  BASE_ADDR));
    end

    // Byte-lane write on an accepted in-range write; storage is never reset.
    always_ff @(posedge clk) begin
        if (bus.data_gnt && bus.data_wr && d_hit) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (bus.data_byteen[i]) begin
                    mem[d_idx][8*i +: 8] <= bus.data_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered responses; reads sample mem before this edge's write lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.instr_valid <= 1'b0;
            bus.instr_err   <= 1'b0;
            bus.instr_rdata <= '0;
            bus.data_valid  <= 1'b0;
            bus.data_rdata  <= '0;
        end else begin
            bus.instr_valid <= bus.instr_req;
            bus.instr_err   <= bus.instr_req && !i_hit;
            if (bus.instr_req) begin
                bus.instr_rdata <= i_hit ? mem[i_idx] : '0;
            end
            bus.data_valid <= bus.data_req;
            if (bus.data_req && !bus.data_wr) begin
                bus.data_rdata <= d_hit ? mem[d_idx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_bus_mem.sv
// Self-checking bench for dual_port_bus_mem: directed vector table, reset
// sequence and randomized traffic against a simple array model.
module tb_dual_port_bus_mem;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    dual_port_bus_mem_if bus ();

    dual_port_bus_mem #(
        .MEM_WORDS (16384),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        eiv;
        logic [31:0] eird;
        logic        eierr;
        logic        edv;
        logic [31:0] edrd;
    } vec_t;

    vec_t vt [15];

    logic [31:0] ref_mem [64];
    logic [31:0] h_ird;
    logic [31:0] h_drd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests, check grants, then advance past the edge.
    task automatic step(input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic dwr, input logic [31:0] daddr,
                        input logic [31:0] wdata, input logic [3:0] be);
        bus.instr_req   = ireq;
        bus.instr_addr  = iaddr;
        bus.data_req    = dreq;
        bus.data_wr     = dwr;
        bus.data_addr   = daddr;
        bus.data_wdata  = wdata;
        bus.data_byteen = be;
        #1;
        chk("instr_gnt", {31'b0, bus.instr_gnt}, {31'b0, ireq});
        chk("data_gnt",  {31'b0, bus.data_gnt},  {31'b0, dreq});
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        step(1'b0, 32'h0, 1'b1, 1'b1, addr, data, 4'hF);
        chk("preload_dvalid", {31'b0, bus.data_valid}, 32'd1);
    endtask

    task automatic chk_resp(input string tag, input logic eiv, input logic [31:0] eird,
                            input logic eierr, input logic edv, input logic [31:0] edrd);
        chk({tag, "_ivalid"}, {31'b0, bus.instr_valid}, {31'b0, eiv});
        chk({tag, "_irdata"}, bus.instr_rdata, eird);
        chk({tag, "_ierr"},   {31'b0, bus.instr_err}, {31'b0, eierr});
        chk({tag, "_dvalid"}, {31'b0, bus.data_valid}, {31'b0, edv});
        chk({tag, "_drdata"}, bus.data_rdata, edrd);
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h0001_0000 + 32'($urandom_range(0, 1023));
        if (r == 1) return $urandom | 32'h8000_0000;
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.instr_req   = 1'b1;
        bus.instr_addr  = 32'h0;
        bus.data_req    = 1'b1;
        bus.data_wr     = 1'b0;
        bus.data_addr   = 32'h0;
        bus.data_wdata  = 32'h0;
        bus.data_byteen = 4'h0;

        // Reset state: outputs cleared and grants suppressed even with requests up.
        #2;
        chk("rst_instr_gnt", {31'b0, bus.instr_gnt}, 32'd0);
        chk("rst_data_gnt",  {31'b0, bus.data_gnt},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_resp("rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        bus.instr_req = 1'b0;
        bus.data_req  = 1'b0;
        reset_n = 1'b1;

        write_word(32'h00, 32'h1111_1111);
        write_word(32'h04, 32'h2222_2222);
        write_word(32'h08, 32'h3333_3333);
        write_word(32'h0C, 32'h4444_4444);
        write_word(32'h20, 32'h1234_5678);

        //          ireq  iaddr          dreq  dwr   daddr          wdata          be     eiv   eird           eierr edv   edrd
        vt[0]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'hF, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_0000};
        vt[1]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'hAABB_CCDD};
        vt[2]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0011, 4'h1, 1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'hAABB_CCDD};
        vt[3]  = '{1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'h4444_4444, 1'b0, 1'b1, 32'hAABB_CC11};
        vt[4]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0100, 32'h9900_0000, 4'h8, 1'b0, 32'h4444_4444, 1'b0, 1'b1, 32'hAABB_CC11};
        vt[5]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 1'b0, 32'h4444_4444, 1'b0, 1'b1, 32'h99BB_CC11};
        vt[6]  = '{1'b1, 32'h0001_0000, 1'b1, 1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h99BB_CC11};
        vt[7]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 32'h0,         4'h0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_0000};
        vt[8]  = '{1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000};
        vt[9]  = '{1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vt[10] = '{1'b1, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vt[11] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0002, 32'h0,         4'h0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h1111_1111};
        vt[12] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_FFFF, 32'h5A5A_5A5A, 4'hF, 1'b0, 32'h1111_1111, 1'b0, 1'b1, 32'h1111_1111};
        vt[13] = '{1'b1, 32'h0000_FFFC, 1'b1, 1'b0, 32'h0000_FFFD, 32'h0,         4'h0, 1'b1, 32'h5A5A_5A5A, 1'b0, 1'b1, 32'h5A5A_5A5A};
        vt[14] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h5A5A_5A5A};

        for (int i = 0; i < 15; i++) begin
            step(vt[i].ireq, vt[i].iaddr, vt[i].dreq, vt[i].dwr, vt[i].daddr, vt[i].wdata, vt[i].be);
            chk_resp($sformatf("vec%0d", i), vt[i].eiv, vt[i].eird, vt[i].eierr, vt[i].edv, vt[i].edrd);
        end

        // Reset while responses are pending: the accepted write stays, later ones are blocked.
        step(1'b1, 32'h4, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
        chk_resp("pre_rst", 1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'h5A5A_5A5A);
        bus.data_wdata = 32'h0BAD_BEEF;
        reset_n = 1'b0;
        #1;
        chk_resp("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("mid_rst_igntd", {31'b0, bus.instr_gnt}, 32'd0);
        chk("mid_rst_dgntd", {31'b0, bus.data_gnt}, 32'd0);
        @(posedge clk);
        #1;
        chk_resp("in_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        bus.instr_req = 1'b0;
        bus.data_req  = 1'b0;
        reset_n = 1'b1;
        step(1'b1, 32'h4, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        chk_resp("post_rst1", 1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'hCAFE_F00D);
        step(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        chk_resp("post_rst2", 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h1111_1111);

        // Randomized traffic over words 0..63 plus out-of-range addresses.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        h_ird = 32'h0;
        h_drd = 32'h0;
        for (int w = 0; w < 64; w++) begin
            ref_mem[w] = $urandom;
            write_word(32'(w * 4), ref_mem[w]);
        end

        for (int c = 0; c < 400; c++) begin
            logic        ireq, dreq, dwr, iin, din;
            logic [31:0] iaddr, daddr, wdata;
            logic [3:0]  be;
            logic        eiv, eierr, edv;

            ireq  = ($urandom_range(0, 3) != 0);
            dreq  = ($urandom_range(0, 3) != 0);
            dwr   = $urandom_range(0, 1) == 1;
            iaddr = pick_addr();
            daddr = pick_addr();
            if ($urandom_range(0, 4) == 0) daddr = iaddr;
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            iin   = iaddr < 32'h0001_0000;
            din   = daddr < 32'h0001_0000;

            eiv   = ireq;
            eierr = ireq && !iin;
            if (ireq) h_ird = iin ? ref_mem[iaddr[7:2]] : 32'h0;
            edv   = dreq;
            if (dreq && !dwr) h_drd = din ? ref_mem[daddr[7:2]] : 32'h0;
            if (dreq && dwr && din) begin
                for (int l = 0; l < 4; l++) begin
                    if (be[l]) ref_mem[daddr[7:2]][8*l +: 8] = wdata[8*l +: 8];
                end
            end

            step(ireq, iaddr, dreq, dwr, daddr, wdata, be);
            chk_resp($sformatf("rnd%0d", c), eiv, h_ird, eierr, edv, h_drd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_bus_mem.md
Name: dual_port_bus_mem

Overview:
- Simulation memory model serving a RISC-V core over two independent request/grant/valid buses: one read-only instruction port and one read/write data port.
- Both ports access a single word-addressed storage array named mem.
- mem is preloadable by hierarchical $readmemh from the enclosing bench.
- Provides single-cycle-latency responses, so core fetch and load/store paths can run with full throughput.

Parameters:
- MEM_WORDS, 16384, number of 32-bit words in mem (64 KiB).
- BASE_ADDR, 32'h0000_0000, byte address mapped to mem[0].

Ports:
- clk  input  1  clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- instr_req  input  1  instruction fetch request.
- instr_addr  input  32  fetch byte address.
- instr_gnt  output  1  fetch request accepted this cycle.
- instr_rdata  output  32  fetched word.
- instr_err  output  1  fetch error, qualified by instr_valid.
- instr_valid  output  1  fetch response valid.
- data_req  input  1  data access request.
- data_wr  input  1  1 = write, 0 = read.
- data_addr  input  32  data byte address.
- data_wdata  input  32  write data, lane-aligned.
- data_byteen  input  4  byte enables; bit i enables data_wdata[8i+7:8i].
- data_gnt  output  1  data request accepted this cycle.
- data_rdata  output  32  read data, full word.
- data_valid  output  1  data response valid.

Behaviour:
- Reset (reset_n low, asynchronous):
  - instr_valid, instr_err, data_valid = 0.
  - instr_rdata, data_rdata = 32'h0.
  - mem contents are never reset, so preloaded data survives reset.
- Grant:
  - instr_gnt = instr_req and data_gnt = data_req, combinationally (always ready).
  - Grants are forced 0 while reset_n is low.
- Latency: a request accepted at edge N produces its response (valid = 1 plus data) during cycle N+1, registered.
- Valid: pulses for exactly one cycle per accepted request. Back-to-back requests give a continuous valid stream with one response per cycle.
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2.
  - In range when addr >= BASE_ADDR and index < MEM_WORDS.
  - addr[1:0] is ignored for indexing.
- Instruction port:
  - In-range fetch: instr_rdata = mem[index], instr_err = 0.
  - Out-of-range fetch: instr_rdata = 32'h0, instr_err = 1.
  - instr_err is 0 whenever instr_valid is 0.
- Data read: data_rdata = mem[index]; returns 32'h0 when out of range.
- Data write:
  - At the accepting edge, each enabled byte lane of mem[index] is updated from data_wdata; disabled lanes are unchanged.
  - data_valid pulses the next cycle; data_rdata is held at its previous value.
  - Out-of-range writes are dropped silently but still get data_valid.
  - byteen = 4'b0000 is a legal no-op write.
- Collisions:
  - Reads and writes hitting the same word in the same cycle are read-before-write: the read returns the old word and the write takes effect after that edge.
  - The two ports are fully independent; there is no arbitration between them.
- rdata hold: rdata holds its last value while the port's valid is 0.
- Reset mid-transaction: a response pending when reset asserts is discarded (valid = 0). A write accepted at an earlier edge remains committed.

Decomposition:
- Shared package holds:
  - bus width constants (ADDR_W = 32, DATA_W = 32, BE_W = 4);
  - the MEM_WORDS default;
  - an addr-to-word-index function, plus an in-range function.
- Single module; no sub-module. The per-lane write loop and the two response registers are small enough to stay inline.

Test Plan:
- Preload mem[0..3] = 11111111, 22222222, 33333333, 44444444. Fetch addr 0, 4, 8, 12 on consecutive cycles -> instr_valid high for 4 consecutive cycles, rdata in the same order, instr_err = 0.
- Data write addr 0x100, wdata AABBCCDD, byteen 1111, then read 0x100 -> data_valid after each request; read returns AABBCCDD.
- Write 0x100 wdata 00000011, byteen 0001, then read -> AABBCC11. Write wdata 99000000, byteen 1000 -> 99BBCC11.
- Fetch addr 0x0001_0000 (index = MEM_WORDS) -> next cycle instr_valid = 1, instr_err = 1, rdata = 0. A data write to the same address -> data_valid = 1 and mem unchanged.
- Same cycle: data write 0x20 = DEADBEEF and fetch 0x20 (old value 12345678) -> fetch returns 12345678; a following fetch returns DEADBEEF.
- Assert reset_n low one cycle after a request is accepted -> instr_valid and data_valid = 0 immediately, rdata = 0; preloaded mem contents intact after release.
